// File: rtl/v2_sum_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | v2_sum_stage : sum/carry/overflow from prefix-network P and G(i:-1),      |
// |                registered into a 2-entry valid/ready output buffer.      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module v2_sum_stage #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     p_in,
   input  logic [W-1:0]     g_pre,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     sum,
   output logic             cout,
   output logic             ovf,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam int               EW        = W + 2;
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [1:0]       C_EMPTY   = 2'd0;
   localparam logic [1:0]       C_FULL    = 2'd2;

   logic [W-1:0]     w_sum;
   logic             w_cout;
   logic             w_ovf;
   logic [EW-1:0]    w_entry;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_cnt_nxt;

   logic [EW-1:0]    r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_cnt;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_xfer;

   // Carry into bit i is G(i-1:-1); bit 0 takes the raw carry-in.
   assign w_sum   = {p_in[W-1:1] ^ g_pre[W-2:0], p_in[0] ^ cin};
   assign w_cout  = g_pre[W-1];
   assign w_ovf   = g_pre[W-1] ^ g_pre[W-2];
   assign w_entry = {w_sum, w_cout, w_ovf};

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = out_valid & out_ready;

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + 2'd1;
         2'b01:   w_cnt_nxt = r_cnt - 2'd1;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_cnt      <= C_EMPTY;
         r_in_ready <= 1'b1;
         r_xfer     <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_cnt      <= w_cnt_nxt;
         r_in_ready <= (w_cnt_nxt < C_FULL);
         // Saturate rather than wrap so a long-running count stays meaningful.
         if (w_pop && (r_xfer != C_CNT_MAX)) begin
            r_xfer <= r_xfer + 1'b1;
         end
      end
   end

   assign {sum, cout, ovf} = r_mem[r_rptr];
   assign out_valid        = (r_cnt != C_EMPTY);
   assign in_ready         = r_in_ready;
   assign xfer_cnt         = r_xfer;

endmodule
`default_nettype wire
